multi_dac: RTL and testbench

// Parametrised multi-channel 1-bit DAC for the Pong CPLD: drives the analogue

---
 rtl/multi_dac.sv | 88 ++++++++
 tb/tb_multi_dac.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_dac.sv
// Multi-channel 1-bit DAC (PWM or first-order sigma-delta) with double-buffered codes
// that are applied only on period boundaries, so a running period is never disturbed.
module multi_dac #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2
) (
  input  logic                      CLK,
  input  logic                      Reset_n,
  input  logic [CHANNELS*WIDTH-1:0] DACin,
  input  logic                      Load,
  input  logic                      Mode,
  output logic [CHANNELS-1:0]       DACout,
  output logic                      Pending,
  output logic                      PeriodStart
);

  logic [WIDTH-1:0]          r_cnt;
  logic [CHANNELS*WIDTH-1:0] r_shadow;
  logic [CHANNELS*WIDTH-1:0] r_active;
  logic [WIDTH-1:0]          r_acc [CHANNELS];
  logic                      r_mode;
  logic                      r_pending;
  logic                      r_period_start;
  logic [CHANNELS-1:0]       r_dacout;

  logic                      w_boundary;
  logic                      w_mode_change;
  logic [WIDTH:0]            w_sum [CHANNELS];
  logic [CHANNELS-1:0]       w_pwm;

  assign w_boundary    = (r_cnt == '1);
  assign w_mode_change = w_boundary && (Mode != r_mode);

  // The carry of each sum is the output bit, so the accumulator only keeps the low WIDTH bits.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      w_sum[c] = {1'b0, r_acc[c]} + {1'b0, r_active[c*WIDTH +: WIDTH]};
      w_pwm[c] = (r_cnt < r_active[c*WIDTH +: WIDTH]);
    end
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      r_cnt          <= '0;
      r_shadow       <= '0;
      r_active       <= '0;
      r_mode         <= 1'b0;
      r_pending      <= 1'b0;
      r_period_start <= 1'b0;
      r_dacout       <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        r_acc[c] <= '0;
      end
    end else begin
      r_cnt          <= r_cnt + 1'b1;
      r_period_start <= (r_cnt == '0);

      if (w_boundary && r_pending) begin
        r_active <= r_shadow;
      end
      // A Load on the boundary cycle refills the shadow, so Pending stays set.
      if (Load) begin
        r_shadow  <= DACin;
        r_pending <= 1'b1;
      end else if (w_boundary) begin
        r_pending <= 1'b0;
      end

      if (w_boundary) begin
        r_mode <= Mode;
      end

      for (int c = 0; c < CHANNELS; c++) begin
        if (w_mode_change) begin
          r_acc[c] <= '0;
        end else if (r_mode) begin
          r_acc[c] <= w_sum[c][WIDTH-1:0];
        end
        r_dacout[c] <= r_mode ? w_sum[c][WIDTH] : w_pwm[c];
      end
    end
  end

  assign DACout      = r_dacout;
  assign Pending     = r_pending;
  assign PeriodStart = r_period_start;

endmodule

// File: tb/tb_multi_dac.sv
// Self-checking bench for multi_dac (WIDTH=8, CHANNELS=2): per-period ones counts are
// queued as expectations when codes are driven, then checked as each period is observed.
module tb_multi_dac;

  logic        CLK;
  logic        Reset_n;
  logic [15:0] DACin;
  logic        Load;
  logic        Mode;
  logic [1:0]  DACout;
  logic        Pending;
  logic        PeriodStart;

  int n_checks = 0;
  int n_fail   = 0;

  // Entry = {ch1 ones count, ch0 ones count} for one observed period.
  logic [17:0] exp_q[$];

  int   m_first0;
  int   m_alt1;
  logic m_contig0;
  logic m_pend_start;
  logic m_pend_after;
  logic m_pend_end;

  multi_dac #(.WIDTH(8), .CHANNELS(2)) dut (
    .CLK         (CLK),
    .Reset_n     (Reset_n),
    .DACin       (DACin),
    .Load        (Load),
    .Mode        (Mode),
    .DACout      (DACout),
    .Pending     (Pending),
    .PeriodStart (PeriodStart)
  );

  // Clock / watchdog
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", tag, got, exp);
    end
  endtask

  task automatic expect_period(input int c0, input int c1);
    exp_q.push_back({9'(c1), 9'(c0)});
  endtask

  // Advance to the next negedge on which PeriodStart is high.
  task automatic sync_period();
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!PeriodStart && n < 600);
    check_eq("sync_period", 32'(PeriodStart), 1);
  endtask

  // Observe one period starting at the current PeriodStart negedge, optionally driving
  // up to two Load strobes and a Mode change at given sample indices.
  task automatic measure(input int l1_idx, input logic [15:0] l1_val,
                         input int l2_idx, input logic [15:0] l2_val,
                         input int mode_idx, input logic mode_val);
    int          ones0 = 0;
    int          ones1 = 0;
    int          ps_cnt = 0;
    bit          seen_zero = 0;
    logic        prev1 = 1'b0;
    logic [17:0] exp;
    m_contig0 = 1'b1;
    m_first0  = -1;
    m_alt1    = 0;
    for (int i = 0; i < 256; i++) begin
      if (i > 0) @(negedge CLK);
      ones0  += int'(DACout[0]);
      ones1  += int'(DACout[1]);
      ps_cnt += int'(PeriodStart);
      if (DACout[0] && seen_zero) m_contig0 = 1'b0;
      if (!DACout[0]) seen_zero = 1;
      if (DACout[0] && m_first0 < 0) m_first0 = i;
      if (i > 0 && DACout[1] != prev1) m_alt1++;
      prev1 = DACout[1];
      if (i == 0) m_pend_start = Pending;
      if (i == l1_idx + 1) m_pend_after = Pending;
      if (i == 254) m_pend_end = Pending;
      if (i == l1_idx) begin
        DACin = l1_val;
        Load  = 1'b1;
      end else if (i == l2_idx) begin
        DACin = l2_val;
        Load  = 1'b1;
      end else begin
        Load = 1'b0;
      end
      if (i == mode_idx) Mode = mode_val;
    end
    if (exp_q.size() == 0) begin
      check_eq("scoreboard_empty", 1, 0);
    end else begin
      exp = exp_q.pop_front();
      check_eq("ones_ch0", 32'(ones0), 32'(exp[8:0]));
      check_eq("ones_ch1", 32'(ones1), 32'(exp[17:9]));
      check_eq("period_start_once", 32'(ps_cnt), 1);
    end
  endtask

  initial begin
    Reset_n = 1'b0;
    Load    = 1'b0;
    Mode    = 1'b0;
    DACin   = '0;
    repeat (3) @(negedge CLK);
    check_eq("rst_dacout", 32'(DACout), 0);
    check_eq("rst_pending", 32'(Pending), 0);
    check_eq("rst_period_start", 32'(PeriodStart), 0);
    Reset_n = 1'b1;
    @(negedge CLK);
    check_eq("ps_after_release", 32'(PeriodStart), 1);

    // Reset mid-period with PWM 0x80 running and a code pending
    expect_period(0, 0);
    measure(5, 16'h8080, -1, '0, -1, 1'b0);
    check_eq("pend_after_load_a", 32'(m_pend_after), 1);
    sync_period();
    expect_period(128, 128);
    measure(-1, '0, 254, 16'h8080, -1, 1'b0);
    check_eq("pwm80_contig", 32'(m_contig0), 1);
    sync_period();
    check_eq("pre_rst_dacout", 32'(DACout), 3);
    check_eq("pre_rst_pending", 32'(Pending), 1);
    #2 Reset_n = 1'b0;
    #1;
    check_eq("async_rst_dacout", 32'(DACout), 0);
    check_eq("async_rst_pending", 32'(Pending), 0);
    check_eq("async_rst_ps", 32'(PeriodStart), 0);
    @(negedge CLK);
    @(negedge CLK);
    Reset_n = 1'b1;
    @(negedge CLK);
    check_eq("ps_after_release2", 32'(PeriodStart), 1);
    check_eq("dacout_after_release", 32'(DACout), 0);

    // PWM codes 0x40 / 0x00, then 0xFF
    expect_period(0, 0);
    measure(20, 16'h0040, -1, '0, -1, 1'b0);
    check_eq("pend_mid_load", 32'(m_pend_after), 1);
    check_eq("pend_until_boundary", 32'(m_pend_end), 1);
    sync_period();
    expect_period(64, 0);
    measure(30, 16'h00FF, -1, '0, -1, 1'b0);
    check_eq("pwm40_contig", 32'(m_contig0), 1);
    check_eq("pwm40_first", 32'(m_first0), 0);
    check_eq("pend_cleared", 32'(m_pend_start), 0);
    sync_period();
    expect_period(255, 0);
    measure(-1, '0, -1, '0, -1, 1'b0);
    check_eq("pwmff_contig", 32'(m_contig0), 1);

    // Double buffering: mid-period Load, then a Load on the boundary cycle
    sync_period();
    expect_period(255, 0);
    measure(100, 16'h1020, 254, 16'h3060, -1, 1'b0);
    check_eq("buf_pend_mid", 32'(m_pend_after), 1);
    check_eq("buf_pend_end", 32'(m_pend_end), 1);
    sync_period();
    expect_period(8'h20, 8'h10);
    measure(-1, '0, -1, '0, -1, 1'b0);
    check_eq("buf_pend_held", 32'(m_pend_start), 1);
    check_eq("buf_contig", 32'(m_contig0), 1);
    sync_period();
    expect_period(8'h60, 8'h30);
    measure(-1, '0, -1, '0, -1, 1'b0);
    check_eq("buf_pend_done", 32'(m_pend_start), 0);

    // Mode switch to sigma-delta mid-period
    sync_period();
    expect_period(8'h60, 8'h30);
    measure(-1, '0, -1, '0, 10, 1'b1);
    check_eq("switch_pwm_completes", 32'(m_contig0), 1);
    sync_period();
    expect_period(8'h60, 8'h30);
    measure(50, 16'h8095, -1, '0, -1, 1'b1);
    check_eq("sd_first_one_60", 32'(m_first0), 2);

    // Sigma-delta 0x95 / 0x80
    sync_period();
    expect_period(8'h95, 8'h80);
    measure(-1, '0, -1, '0, -1, 1'b1);
    check_eq("sd80_alternation", 32'(m_alt1), 255);

    // Reset during sigma-delta with a code pending
    sync_period();
    repeat (40) @(negedge CLK);
    DACin = 16'h2211;
    Load  = 1'b1;
    @(negedge CLK);
    Load = 1'b0;
    check_eq("sd_pend_before_rst", 32'(Pending), 1);
    #2 Reset_n = 1'b0;
    #1;
    check_eq("sd_rst_dacout", 32'(DACout), 0);
    check_eq("sd_rst_pending", 32'(Pending), 0);
    check_eq("sd_rst_ps", 32'(PeriodStart), 0);
    @(negedge CLK);
    @(negedge CLK);
    Reset_n = 1'b1;
    sync_period();
    expect_period(0, 0);
    measure(20, 16'h0040, -1, '0, -1, 1'b1);
    sync_period();
    expect_period(64, 0);
    measure(-1, '0, -1, '0, -1, 1'b1);
    check_eq("sd_first_one_40", 32'(m_first0), 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
